dlx_scoreboard: RTL
===================

Name: dlx_scoreboard

Overview:
- Register-hazard scheduler for the DLX pipeline. Sits between decode and the 32x32 register file.
- Tracks outstanding writes per architectural register using per-register pending counters.
- Holds an instruction in decode (RAW or pending-counter overflow) until its sources can be read from the file or its same-cycle write-back bypass.
- Releases pending entries on write-back; supports a pipeline flush.

Parameters:
- CNT_W, 2, width of each per-register pending-write counter (max in-flight writes per register = 2^CNT_W - 1).
- TOT_W, 6, width of the global in-flight write counter.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  decode presents an instruction.
- id_ready  out  1  instruction accepted this cycle (= !stall).
- id_rs1  in  5  source register 1 number.
- id_rs2  in  5  source register 2 number.
- id_use_rs1  in  1  instruction reads rs1.
- id_use_rs2  in  1  instruction reads rs2.
- id_rd  in  5  destination register number.
- id_wr  in  1  instruction writes rd.
- wb_valid  in  1  write-back stage commits a write this cycle (the register file's WB).
- wb_rd  in  5  write-back destination (the register file's Rd).
- flush  in  1  kill all in-flight writes.
- stall  out  1  decode must hold.
- busy_vec  out  32  bit i = pending count of register i is non-zero.
- pending_total  out  TOT_W  total in-flight writes.
- err_underflow  out  1  sticky: write-back to a register with zero pending count.
- err_clr  in  1  clears err_underflow.

Behaviour:
- Reset (async, rst_n=0): all counters 0, busy_vec=0, pending_total=0, err_underflow=0. Outputs take these values immediately, not at the next edge. Stall is combinational and is 0 after reset.
- Register 0: never counted; id_rd=0 or wb_rd=0 is ignored; sources equal to 0 never stall.
- Source hazard, evaluated for each source s with use bit set and s!=0:
  - hazard if cnt[s] > 1;
  - or cnt[s] == 1 and not (wb_valid && wb_rd == s).
  - A single pending write retiring this cycle is covered by the register file's same-cycle bypass, so it does not stall.
- Overflow hazard: id_wr && id_rd != 0 && cnt[id_rd] == max && not (wb_valid && wb_rd == id_rd).
- stall = id_valid && (source hazard || overflow hazard). Purely combinational, zero latency. id_ready = !stall.
- Issue: fires when id_valid && !stall && id_wr && id_rd != 0 && !flush.
- Counter update per register r at posedge:
  - +1 if issue fires to r;
  - -1 if wb_valid && wb_rd == r && cnt[r] > 0;
  - both together: unchanged.
- Underflow: wb_valid to r != 0 with cnt[r] == 0 leaves the counter at 0 and sets err_underflow on the next edge.
- err_clr clears err_underflow at the edge. If underflow and err_clr occur in the same cycle, the set wins.
- pending_total tracks the sum of all counters with the same +1/-1/net-0 rule and saturates at 2^TOT_W-1.
- Flush: at the edge, all counters and pending_total go to 0. Any issue or write-back in the same cycle is discarded. err_underflow is unaffected.
- busy_vec is registered-derived: bit i = |cnt[i]. It reflects state after the most recent edge.
- An instruction held by stall keeps its inputs stable. The scoreboard is stateless with respect to the held instruction; no state changes occur on its behalf.

Test Plan:
- Reset mid-operation: issue to r5 and r6, then drop rst_n for half a cycle -> busy_vec=0, pending_total=0, stall=0 immediately, before any clock edge.
- RAW stall: issue rd=3; next cycle decode rs1=3, use_rs1=1 -> stall=1. Hold until wb_valid with wb_rd=3 -> stall=0 in that same cycle; instruction accepted; cnt[3]=0 after the edge.
- Double pending: issue rd=7 twice with no write-back (cnt=2); consumer of r7 -> stall through the first write-back, released only during the second write-back cycle.
- Overflow (CNT_W=2): three issues to rd=9 -> fourth writer of r9 stalls. With wb_rd=9 in the same cycle it issues; cnt[9] stays 3.
- Simultaneous issue and write-back on r4 with cnt=1 -> cnt[4] stays 1, pending_total unchanged. Write-back to r0 or to an idle r12 -> r0 ignored; r12 sets err_underflow=1, which clears only on err_clr.
- Flush: three registers pending, flush asserted together with an issue to r2 -> after the edge busy_vec=0, pending_total=0, r2 not busy.

Source files
------------

// File: rtl/dlx_scoreboard.sv
// rtl/dlx_scoreboard.sv - DLX register-hazard scoreboard with per-register pending-write counters
// Holds decode on RAW or counter overflow; a single write retiring this cycle is covered by the file bypass.
module dlx_scoreboard #(
  parameter int CNT_W = 2,
  parameter int TOT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  output logic             id_ready,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_wr,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  input  logic             flush,
  output logic             stall,
  output logic [31:0]      busy_vec,
  output logic [TOT_W-1:0] pending_total,
  output logic             err_underflow,
  input  logic             err_clr
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [TOT_W-1:0] TOT_MAX = '1;

  logic [CNT_W-1:0] cnt_q [32];
  logic [CNT_W-1:0] cnt_d [32];
  logic [TOT_W-1:0] total_q, total_d;
  logic             err_q, err_d;

  logic [CNT_W-1:0] c_rs1, c_rs2, c_rd, c_wb;
  logic             haz_rs1, haz_rs2, haz_ovf;
  logic             issue, retire, underflow;

  assign c_rs1 = cnt_q[id_rs1];
  assign c_rs2 = cnt_q[id_rs2];
  assign c_rd  = cnt_q[id_rd];
  assign c_wb  = cnt_q[wb_rd];

  // One pending write that is retiring right now is readable through the bypass.
  assign haz_rs1 = id_use_rs1 && (id_rs1 != 5'd0) &&
                   ((c_rs1 > CNT_W'(1)) ||
                    ((c_rs1 == CNT_W'(1)) && !(wb_valid && (wb_rd == id_rs1))));
  assign haz_rs2 = id_use_rs2 && (id_rs2 != 5'd0) &&
                   ((c_rs2 > CNT_W'(1)) ||
                    ((c_rs2 == CNT_W'(1)) && !(wb_valid && (wb_rd == id_rs2))));
  assign haz_ovf = id_wr && (id_rd != 5'd0) && (c_rd == CNT_MAX) &&
                   !(wb_valid && (wb_rd == id_rd));

  assign stall     = id_valid && (haz_rs1 || haz_rs2 || haz_ovf);
  assign id_ready  = !stall;
  assign issue     = id_valid && !stall && id_wr && (id_rd != 5'd0) && !flush;
  assign retire    = wb_valid && (wb_rd != 5'd0) && (c_wb != '0);
  assign underflow = wb_valid && (wb_rd != 5'd0) && (c_wb == '0);

  always_comb begin
    for (int r = 0; r < 32; r++) begin
      cnt_d[r] = cnt_q[r];
      if (flush) begin
        cnt_d[r] = '0;
      end else if (issue && (id_rd == 5'(r)) && !(retire && (wb_rd == 5'(r)))) begin
        cnt_d[r] = cnt_q[r] + CNT_W'(1);
      end else if (retire && (wb_rd == 5'(r)) && !(issue && (id_rd == 5'(r)))) begin
        cnt_d[r] = cnt_q[r] - CNT_W'(1);
      end
    end
  end

  always_comb begin
    total_d = total_q;
    if (flush) begin
      total_d = '0;
    end else if (issue && !retire) begin
      total_d = (total_q == TOT_MAX) ? total_q : total_q + TOT_W'(1);
    end else if (retire && !issue && (total_q != '0)) begin
      total_d = total_q - TOT_W'(1);
    end
  end

  always_comb begin
    err_d = err_q;
    if (underflow) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) begin
        cnt_q[r] <= '0;
      end
      total_q <= '0;
      err_q   <= 1'b0;
    end else begin
      for (int r = 0; r < 32; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      total_q <= total_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    busy_vec = '0;
    for (int r = 0; r < 32; r++) begin
      busy_vec[r] = (cnt_q[r] != '0);
    end
  end

  assign pending_total = total_q;
  assign err_underflow = err_q;

endmodule
